// File: rtl/i2s_rx_deserializer_if.sv
// PCM output bundle of the I2S receiver: per-channel data words, valid strobes, error status.
// Latency: none (wires only).
// Backpressure: none; strobes are fire-and-forget, consumers must take every word.
//
// Ports (master = receiver, slave = consumer such as the FIR l/r data_en/data_in inputs):
//   l_dout_valid / r_dout_valid  1-clk strobes, l_pcm_data / r_pcm_data updated
//   l_pcm_data / r_pcm_data      last complete word per channel (DATA_W bits)
//   frame_err                    1-clk strobe on a short slot (I2S_RX_FRAME_ERR_EN builds only)
//   err_count                    saturating short-slot count (I2S_RX_FRAME_ERR_EN builds only)
interface i2s_rx_deserializer_if #(
    parameter int DATA_W = 24
);
    logic              l_dout_valid;
    logic              r_dout_valid;
    logic [DATA_W-1:0] l_pcm_data;
    logic [DATA_W-1:0] r_pcm_data;
    logic              frame_err;
    logic [7:0]        err_count;

    modport master (
        output l_dout_valid, r_dout_valid, l_pcm_data, r_pcm_data, frame_err, err_count
    );

    modport slave (
        input  l_dout_valid, r_dout_valid, l_pcm_data, r_pcm_data, frame_err, err_count
    );
endinterface

// File: rtl/i2s_rx_deserializer.sv
// Slave-mode I2S receiver: oversamples async bclk/lrclk/data, emits one left and one right word per frame.
// Latency: valid 4 clk (+1 for async sampling) after the pin-level bclk rise carrying the word LSB.
// Backpressure: none; each word is presented with a single-cycle strobe and held until replaced.
//
// Ports:
//   clk, reset_n        system clock (bclk must be <= clk/4), asynchronous active-low reset
//   audio_en            0 = receiver idle and flushed; data outputs hold
//   i2s_bclk/lrclk/d    external I2S pins, asynchronous to clk
//   pcm (master)        l/r strobes and data, frame_err, err_count
// Optional feature macro: I2S_RX_FRAME_ERR_EN builds short-slot detection (frame_err, err_count);
// without it both outputs are tied to 0.
module i2s_rx_deserializer #(
    parameter int DATA_W     = 24,
    parameter bit LEFT_LEVEL = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  audio_en,
    input  logic                  i2s_bclk,
    input  logic                  i2s_lrclk,
    input  logic                  i2s_d,
    i2s_rx_deserializer_if.master pcm
);
    localparam logic [5:0] CNT_DW  = 6'(DATA_W);
    localparam logic [5:0] CNT_MAX = 6'd63;

    // Two-flop synchronisers; bclk_prev gives the rising-edge detector its history.
    logic [1:0]        bclk_sync;
    logic [1:0]        lr_sync;
    logic [1:0]        d_sync;
    logic              bclk_prev;
    logic              bclk_rise;

    logic              lr_prev;
    logic              lr_seen;     // lr_prev holds a real sample from an earlier edge
    logic              slot_start;

    logic              armed;
    logic              channel;
    logic [5:0]        bit_cnt;
    logic [5:0]        bit_nxt;
    logic [DATA_W-1:0] shreg;
    logic              cap_pend;

    logic              l_vld_q;
    logic              r_vld_q;
    logic [DATA_W-1:0] l_dat_q;
    logic [DATA_W-1:0] r_dat_q;

    assign bclk_rise  = bclk_sync[1] & ~bclk_prev;
    assign slot_start = bclk_rise & lr_seen & (lr_sync[1] != lr_prev);
    assign bit_nxt    = (bit_cnt == CNT_MAX) ? CNT_MAX : bit_cnt + 6'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            d_sync    <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[0], i2s_bclk};
            lr_sync   <= {lr_sync[0], i2s_lrclk};
            d_sync    <= {d_sync[0], i2s_d};
            bclk_prev <= bclk_sync[1];
        end
    end

    // lrclk history keeps tracking while disabled so that re-enabling mid-slot does not
    // mistake the current level for a fresh slot boundary. The first edge after reset
    // only loads history, so a slot already in progress can never arm the capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lr_prev <= 1'b0;
            lr_seen <= 1'b0;
        end else if (bclk_rise) begin
            lr_prev <= lr_sync[1];
            lr_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            armed    <= 1'b0;
            channel  <= 1'b0;
            cap_pend <= 1'b0;
        end else if (!audio_en) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            armed    <= 1'b0;
            cap_pend <= 1'b0;
        end else begin
            cap_pend <= 1'b0;
            if (slot_start) begin
                // The bit on this edge is the previous slot's LSB (one-bit delay): drop it.
                bit_cnt <= '0;
                armed   <= 1'b1;
                channel <= lr_sync[1];
            end else if (bclk_rise) begin
                bit_cnt <= bit_nxt;
                if (bit_nxt <= CNT_DW) begin
                    shreg <= {shreg[DATA_W-2:0], d_sync[1]};
                end
                if (armed && (bit_nxt == CNT_DW)) begin
                    cap_pend <= 1'b1;
                end
            end
        end
    end

    // shreg is stable for the cycle after cap_pend since bclk edges are >= 4 clk apart.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l_vld_q <= 1'b0;
            r_vld_q <= 1'b0;
            l_dat_q <= '0;
            r_dat_q <= '0;
        end else begin
            l_vld_q <= 1'b0;
            r_vld_q <= 1'b0;
            if (audio_en && cap_pend) begin
                if (channel == LEFT_LEVEL) begin
                    l_vld_q <= 1'b1;
                    l_dat_q <= shreg;
                end else begin
                    r_vld_q <= 1'b1;
                    r_dat_q <= shreg;
                end
            end
        end
    end

    assign pcm.l_dout_valid = l_vld_q;
    assign pcm.r_dout_valid = r_vld_q;
    assign pcm.l_pcm_data   = l_dat_q;
    assign pcm.r_pcm_data   = r_dat_q;

`ifdef I2S_RX_FRAME_ERR_EN
    logic       fe_q;
    logic [7:0] ec_q;

    // A slot is short when the boundary arrives after at least one data bit but before
    // the word LSB was shifted; unarmed (partial) slots are never counted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fe_q <= 1'b0;
            ec_q <= '0;
        end else if (!audio_en) begin
            fe_q <= 1'b0;
            ec_q <= '0;
        end else begin
            fe_q <= 1'b0;
            if (slot_start && armed && (bit_cnt != 6'd0) && (bit_cnt < CNT_DW)) begin
                fe_q <= 1'b1;
                if (ec_q != 8'hFF) begin
                    ec_q <= ec_q + 8'd1;
                end
            end
        end
    end

    assign pcm.frame_err = fe_q;
    assign pcm.err_count = ec_q;
`else
    assign pcm.frame_err = 1'b0;
    assign pcm.err_count = 8'd0;
`endif
endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Bench for the I2S receiver: drives I2S frames, scoreboards expected words against strobes.
// Latency: n/a.
// Backpressure: n/a; the monitor consumes every strobe.
`timescale 1ns/1ps
module tb_i2s_rx_deserializer;
    typedef struct {
        logic        left;
        logic [23:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic audio_en = 1'b0;
    logic i2s_bclk = 1'b0;
    logic i2s_lrclk = 1'b0;
    logic i2s_d = 1'b0;

    int   n_vec = 0;
    int   n_bad = 0;
    int   fe_cnt = 0;
    int   hp = 40;              // bclk half period in ns
    exp_t exp_q[$];
    logic [23:0] last_l = '0;
    logic [23:0] last_r = '0;

    i2s_rx_deserializer_if #(.DATA_W(24)) pcm ();

    i2s_rx_deserializer #(.DATA_W(24), .LEFT_LEVEL(1'b0)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .audio_en  (audio_en),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_d     (i2s_d),
        .pcm       (pcm)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One bclk period: data and lrclk change on the falling edge, receiver samples on the rise.
    task automatic bclk_bit(input logic lr, input logic d);
        i2s_bclk  = 1'b0;
        i2s_lrclk = lr;
        i2s_d     = d;
        #(hp);
        i2s_bclk  = 1'b1;
        #(hp);
    endtask

    // Bit 0 of a slot carries the previous slot's tail (I2S delay), bits 1..24 the word MSB first.
    task automatic send_slot(input logic lr, input logic [23:0] word, input int nbits,
                             input logic pad, input bit expect_cap);
        exp_t e;
        if (expect_cap) begin
            e.left = (lr == 1'b0);
            e.data = word;
            exp_q.push_back(e);
            if (e.left) last_l = word;
            else        last_r = word;
        end
        for (int k = 0; k < nbits; k++) begin
            if (k == 0 || k > 24) bclk_bit(lr, pad);
            else                  bclk_bit(lr, word[24-k]);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_l_vld"}, 32'(pcm.l_dout_valid), 32'd0);
        check_eq({tag, "_r_vld"}, 32'(pcm.r_dout_valid), 32'd0);
        check_eq({tag, "_l_dat"}, 32'(pcm.l_pcm_data), 32'd0);
        check_eq({tag, "_r_dat"}, 32'(pcm.r_pcm_data), 32'd0);
        check_eq({tag, "_ferr"}, 32'(pcm.frame_err), 32'd0);
        check_eq({tag, "_ecnt"}, 32'(pcm.err_count), 32'd0);
    endtask

    // Scoreboard monitor, sampling on the falling clk edge.
    always @(negedge clk) begin
        exp_t e;
        if (pcm.frame_err) fe_cnt++;
        if (pcm.l_dout_valid || pcm.r_dout_valid) begin
            check_eq("single_strobe", 32'(pcm.l_dout_valid & pcm.r_dout_valid), 32'd0);
            check_eq("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("channel", 32'(pcm.l_dout_valid), 32'(e.left));
                if (pcm.l_dout_valid) check_eq("l_data", 32'(pcm.l_pcm_data), 32'(e.data));
                else                  check_eq("r_data", 32'(pcm.r_pcm_data), 32'(e.data));
            end
        end
    end

    initial begin
        logic [23:0] wl;
        logic [23:0] wr;

        // Reset state
        #23;
        check_outputs_zero("reset");
        reset_n  = 1'b1;
        audio_en = 1'b1;
        #37;

        // 1: fixed pattern, 32-bit slots; the lead-in right slot is unarmed
        hp = 40;
        send_slot(1'b1, 24'h000000, 32, 1'b0, 1'b0);
        for (int f = 0; f < 4; f++) begin
            send_slot(1'b0, 24'hA5A5A5, 32, 1'b0, 1'b1);
            send_slot(1'b1, 24'h5A5A5A, 32, 1'b0, 1'b1);
        end

        // 2: padding ones ignored; a 25-bit slot is the shortest that still completes
        send_slot(1'b0, 24'h123456, 32, 1'b1, 1'b1);
        send_slot(1'b1, 24'hFEDCBA, 32, 1'b1, 1'b1);
        send_slot(1'b0, 24'h800001, 25, 1'b0, 1'b1);
        send_slot(1'b1, 24'h7FFFFE, 25, 1'b1, 1'b1);

        // 3: reset at left bit 10, then resume
        for (int k = 0; k <= 10; k++) bclk_bit(1'b0, k[0]);
        #(hp/2);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        for (int k = 11; k < 14; k++) bclk_bit(1'b0, 1'b1);
        reset_n = 1'b1;
        for (int k = 14; k < 32; k++) bclk_bit(1'b0, 1'b1);
        last_l = '0;
        last_r = '0;
        send_slot(1'b1, 24'hC3C3C3, 32, 1'b0, 1'b1);
        send_slot(1'b0, 24'h000001, 32, 1'b0, 1'b1);
        send_slot(1'b1, 24'h0F0F0F, 32, 1'b0, 1'b1);

        // 4: left slot cut to 16 bits
        fe_cnt = 0;
        send_slot(1'b0, 24'hBADBAD, 16, 1'b0, 1'b0);
        send_slot(1'b1, 24'h3C3C3C, 32, 1'b0, 1'b1);
        check_eq("short_l_hold", 32'(pcm.l_pcm_data), 32'(last_l));
`ifdef I2S_RX_FRAME_ERR_EN
        check_eq("short_ferr_pulses", 32'(fe_cnt), 32'd1);
        check_eq("short_err_count", 32'(pcm.err_count), 32'd1);
`else
        check_eq("short_ferr_pulses", 32'(fe_cnt), 32'd0);
        check_eq("short_err_count", 32'(pcm.err_count), 32'd0);
`endif

        // 5: audio_en low for 3 frames, re-enabled in mid left slot
        audio_en = 1'b0;
        for (int f = 0; f < 3; f++) begin
            send_slot(1'b0, 24'h111111, 32, 1'b0, 1'b0);
            send_slot(1'b1, 24'h222222, 32, 1'b0, 1'b0);
        end
        check_eq("dis_l_hold", 32'(pcm.l_pcm_data), 32'(last_l));
        check_eq("dis_r_hold", 32'(pcm.r_pcm_data), 32'(last_r));
        check_eq("dis_err_count", 32'(pcm.err_count), 32'd0);
        for (int k = 0; k < 32; k++) begin
            if (k == 8) audio_en = 1'b1;
            bclk_bit(1'b0, 1'b1);
        end
        send_slot(1'b1, 24'h654321, 32, 1'b0, 1'b1);
        send_slot(1'b0, 24'hABCDEF, 32, 1'b0, 1'b1);

        // 6: bclk = clk/4, random words
        hp = 20;
        for (int f = 0; f < 100; f++) begin
            wl = 24'($urandom);
            wr = 24'($urandom);
            send_slot(1'b1, wr, 32, 1'b0, 1'b1);
            send_slot(1'b0, wl, 32, 1'b0, 1'b1);
        end

        repeat (20) @(posedge clk);
        check_eq("missed_strobes", 32'(exp_q.size()), 32'd0);
        check_eq("final_l", 32'(pcm.l_pcm_data), 32'(last_l));
        check_eq("final_r", 32'(pcm.r_pcm_data), 32'(last_r));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
